// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - loadable instruction memory with 1-cycle registered fetch
// Optional per-word even parity: define PROG_MEM_PARITY_EN.
module prog_mem #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 5,
    parameter int                 DEPTH    = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   prog_len,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_fault,
    output logic              parity_err
);

`ifdef PROG_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_READY
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] load_ptr;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  store_word;
    logic [MEM_W-1:0]  rd_word;
    logic              wr_en;
    logic              last_word;
    logic              in_range;

    // load_ready is registered and equals (state == S_LOAD)
    assign wr_en     = load_ready && load_valid && !load_start;
    assign last_word = load_last || (load_ptr == LAST_IDX);
    assign in_range  = {1'b0, fetch_addr} < prog_len;
    assign rd_word   = mem[fetch_addr];

`ifdef PROG_MEM_PARITY_EN
    assign store_word = {^load_data, load_data};
`else
    assign store_word = load_data;
`endif

    // Storage is never cleared; prog_len gates what is reachable
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[load_ptr] <= store_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_EMPTY;
            load_ptr    <= '0;
            prog_len    <= '0;
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            addr_fault  <= 1'b0;
            parity_err  <= 1'b0;
            load_done   <= 1'b0;
            load_ready  <= 1'b0;
        end else begin
            load_done   <= 1'b0;
            instr_valid <= 1'b0;
            addr_fault  <= 1'b0;
            parity_err  <= 1'b0;
            if (load_start) begin
                state      <= S_LOAD;
                load_ptr   <= '0;
                prog_len   <= '0;
                load_ready <= 1'b1;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (load_valid) begin
                            if (last_word) begin
                                state      <= S_READY;
                                prog_len   <= {1'b0, load_ptr} + (ADDR_W+1)'(1);
                                load_done  <= 1'b1;
                                load_ready <= 1'b0;
                            end else begin
                                load_ptr <= load_ptr + ADDR_W'(1);
                            end
                        end
                    end
                    default: begin
                        // EMPTY has prog_len=0, so every fetch there faults
                        if (fetch_en) begin
                            instr_valid <= 1'b1;
                            if (in_range) begin
`ifdef PROG_MEM_PARITY_EN
                                if (^rd_word) begin
                                    instr      <= NOP_WORD;
                                    parity_err <= 1'b1;
                                end else begin
                                    instr <= rd_word[DATA_W-1:0];
                                end
`else
                                instr <= rd_word;
`endif
                            end else begin
                                instr      <= NOP_WORD;
                                addr_fault <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// tb/tb_prog_mem.sv - randomized self-checking bench for prog_mem
module tb_prog_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic [5:0]  prog_len;
    logic        fetch_en;
    logic [4:0]  fetch_addr;
    logic [15:0] instr;
    logic        instr_valid;
    logic        addr_fault;
    logic        parity_err;

    prog_mem dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .prog_len   (prog_len),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .addr_fault (addr_fault),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] model_mem [32];
    int          model_len = 0;
    logic [15:0] last_instr = 16'h0000;
    logic [15:0] img [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous valid, 1: two on / one off, 2: random gaps
    task automatic do_load(input int mode, input bit with_last);
        int i = 0;
        int c = 0;
        bit done = 0;
        bit v;
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        fetch_en   = 1'b0;
        step();
        load_start = 1'b0;
        model_len  = 0;
        chk("load_ready_in_load", load_ready, 1);
        chk("prog_len_cleared", prog_len, 0);
        while (!done && c < 400 && i < img.size()) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 != 2) : ($urandom_range(0, 3) != 0);
            load_valid = v;
            load_data  = img[i];
            load_last  = v && with_last && (i == img.size() - 1);
            step();
            c++;
            if (v) begin
                model_mem[i] = img[i];
                done = (with_last && i == img.size() - 1) || (i == 31);
                chk("load_done", load_done, done);
                if (done) model_len = i + 1;
                i++;
            end else begin
                chk("load_done_idle", load_done, 0);
            end
        end
        if (!done) chk("load_timeout", 0, 1);
        while (i < img.size()) begin
            load_valid = 1'b1;
            load_data  = img[i];
            load_last  = 1'b0;
            step();
            chk("late_word_done", load_done, 0);
            i++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        step();
        chk("load_done_end", load_done, 0);
        chk("prog_len", prog_len, model_len);
        chk("load_ready_after", load_ready, 0);
    endtask

    task automatic fetch_cycle(input bit en, input logic [4:0] a);
        logic [15:0] exp;
        fetch_en   = en;
        fetch_addr = a;
        step();
        if (en) begin
            exp = (int'(a) < model_len) ? model_mem[a] : 16'h0000;
            chk("instr", instr, exp);
            chk("instr_valid", instr_valid, 1);
            chk("addr_fault", addr_fault, int'(a) >= model_len);
            chk("parity_err", parity_err, 0);
            last_instr = exp;
        end else begin
            chk("instr_hold", instr, last_instr);
            chk("idle_valid", instr_valid, 0);
            chk("idle_fault", addr_fault, 0);
        end
    endtask

    initial begin
        rst = 1'b1; load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
        fetch_en = 0; fetch_addr = 0;
        step();
        step();
        rst = 1'b0;
        chk("rst_instr", instr, 16'h0000);
        chk("rst_valid", instr_valid, 0);
        chk("rst_fault", addr_fault, 0);
        chk("rst_parity", parity_err, 0);
        chk("rst_done", load_done, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_len", prog_len, 0);

        fetch_cycle(1, 5'd0);
        fetch_cycle(0, 5'd0);

        img = '{16'hE005, 16'hE308, 16'h0530, 16'h1A2B, 16'h3C4D,
                16'h5E6F, 16'h7081, 16'h92A3, 16'hB4C5};
        do_load(1, 1'b1);
        for (int a = 0; a < 9; a++) fetch_cycle(1, 5'(a));
        fetch_cycle(1, 5'd9);
        fetch_cycle(1, 5'd31);
        fetch_cycle(0, 5'd3);

        img.delete();
        for (int k = 0; k < 40; k++) img.push_back(16'($urandom));
        do_load(0, 1'b0);
        fetch_cycle(1, 5'd0);
        fetch_cycle(1, 5'd31);
        fetch_cycle(1, 5'd16);

        load_start = 1'b1;
        step();
        load_start = 1'b0;
        model_len  = 0;
        for (int k = 0; k < 4; k++) begin
            load_valid = 1'b1;
            load_data  = 16'hA000 + 16'(k);
            step();
        end
        load_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_instr = 16'h0000;
        chk("midrst_len", prog_len, 0);
        chk("midrst_ready", load_ready, 0);
        chk("midrst_instr", instr, 16'h0000);
        fetch_cycle(1, 5'd0);

        img = '{16'h0F0F, 16'h1234, 16'hFFFF};
        do_load(2, 1'b1);
        for (int a = 0; a < 4; a++) fetch_cycle(1, 5'(a));

        fetch_en   = 1'b1;
        fetch_addr = 5'd0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        model_len  = 0;
        chk("start_fetch_valid", instr_valid, 0);
        chk("start_fetch_ready", load_ready, 1);
        step();
        chk("load_fetch_ignored", instr_valid, 0);
        fetch_en = 1'b0;
        img = '{16'h4444, 16'h5555, 16'h6666};
        do_load(0, 1'b1);
        for (int a = 0; a < 3; a++) fetch_cycle(1, 5'(a));

`ifdef PROG_MEM_PARITY_EN
        dut.mem[2][0] = ~dut.mem[2][0];
        fetch_en   = 1'b1;
        fetch_addr = 5'd2;
        step();
        chk("par_instr", instr, 16'h0000);
        chk("par_err", parity_err, 1);
        chk("par_valid", instr_valid, 1);
        chk("par_fault", addr_fault, 0);
        last_instr = 16'h0000;
        fetch_cycle(1, 5'd1);
        img = '{16'h4444, 16'h5555, 16'h6666};
        do_load(0, 1'b1);
`endif

        for (int r = 0; r < 6; r++) begin
            int n;
            bit wl;
            n = $urandom_range(1, 40);
            img.delete();
            for (int k = 0; k < n; k++) img.push_back(16'($urandom));
            wl = (n < 32) ? 1'b1 : 1'($urandom_range(0, 1));
            do_load(2, wl);
            for (int k = 0; k < 30; k++) begin
                load_valid = 1'($urandom_range(0, 1));
                load_data  = 16'($urandom);
                fetch_cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)));
            end
            load_valid = 1'b0;
            chk("rand_len_stable", prog_len, model_len);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
